// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } FwdSel;

  typedef enum logic [1:0] {
    HS_RUN   = 2'b00,
    HS_WAIT  = 2'b01,
    HS_ERROR = 2'b10
  } HazardState;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Inc,
  output logic [WIDTH-1:0] o_Count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_Inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) count_q <= '0;
    else          count_q <= count_d;
  end

  assign o_Count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV32 pipeline control: forwarding selects, RAW/load-use stall,
// taken-branch flush and memory-wait freeze with timeout, plus perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_WIDTH   = 5,
  parameter int COUNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int FWD_ENABLE  = 1
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [REG_WIDTH-1:0]   i_ID_Rs1,
  input  logic [REG_WIDTH-1:0]   i_ID_Rs2,
  input  logic                   i_ID_Rs1Used,
  input  logic                   i_ID_Rs2Used,
  input  logic [REG_WIDTH-1:0]   i_EX_Rs1,
  input  logic [REG_WIDTH-1:0]   i_EX_Rs2,
  input  logic [REG_WIDTH-1:0]   i_EX_Rd,
  input  logic                   i_EX_RegWrEnable,
  input  logic                   i_EX_IsLoad,
  input  logic [REG_WIDTH-1:0]   i_MEM_Rd,
  input  logic                   i_MEM_RegWrEnable,
  input  logic                   i_MEM_MemAccess,
  input  logic [REG_WIDTH-1:0]   i_WB_Rd,
  input  logic                   i_WB_RegWrEnable,
  input  logic                   i_BranchTaken,
  input  logic                   i_MemAck,
  output logic                   o_MemReq,
  output logic [1:0]             o_FwdA,
  output logic [1:0]             o_FwdB,
  output logic                   o_StallIF,
  output logic                   o_StallID,
  output logic                   o_BubbleEX,
  output logic                   o_FlushID,
  output logic                   o_Freeze,
  output logic                   o_Error,
  output logic [COUNT_WIDTH-1:0] o_StallCount,
  output logic [COUNT_WIDTH-1:0] o_FlushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  HazardState        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [REG_WIDTH-1:0] id_rs [2];
  logic                 id_used [2];
  logic [REG_WIDTH-1:0] ex_rs [2];

  assign id_rs[0]   = i_ID_Rs1;
  assign id_rs[1]   = i_ID_Rs2;
  assign id_used[0] = i_ID_Rs1Used;
  assign id_used[1] = i_ID_Rs2Used;
  assign ex_rs[0]   = i_EX_Rs1;
  assign ex_rs[1]   = i_EX_Rs2;

  // Per-operand forwarding select and hazard detection; x0 never matches.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    FwdSel fwd_sel;
    logic  id_live;
    logic  hit_load;
    logic  hit_any;

    always_comb begin
      fwd_sel = FWD_REG;
      if ((FWD_ENABLE != 0) && (ex_rs[gi] != '0)) begin
        if (i_MEM_RegWrEnable && (i_MEM_Rd == ex_rs[gi]))   fwd_sel = FWD_MEM;
        else if (i_WB_RegWrEnable && (i_WB_Rd == ex_rs[gi])) fwd_sel = FWD_WB;
      end
    end

    assign id_live  = id_used[gi] && (id_rs[gi] != '0);
    assign hit_load = id_live && i_EX_IsLoad && (i_EX_Rd == id_rs[gi]);
    assign hit_any  = id_live && ((i_EX_RegWrEnable  && (i_EX_Rd  == id_rs[gi])) ||
                                  (i_MEM_RegWrEnable && (i_MEM_Rd == id_rs[gi])) ||
                                  (i_WB_RegWrEnable  && (i_WB_Rd  == id_rs[gi])));
  end

  logic hazard, mem_req, freeze, branch_act, stall_act;

  assign hazard = (FWD_ENABLE != 0) ? (g_src[0].hit_load || g_src[1].hit_load)
                                    : (g_src[0].hit_any  || g_src[1].hit_any);

  always_comb begin
    mem_req    = i_MEM_MemAccess && (state_q != HS_ERROR);
    freeze     = (mem_req && !i_MemAck) || (state_q == HS_ERROR);
    branch_act = i_BranchTaken && !freeze;
    stall_act  = hazard && !freeze && !branch_act;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      HS_RUN: begin
        if (mem_req && !i_MemAck) begin
          state_d = HS_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      HS_WAIT: begin
        if (i_MemAck) begin
          state_d = HS_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = HS_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HS_ERROR: ;
      default: begin
        state_d = HS_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= HS_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Asserted reset forces every control output quiet, even mid-access.
  assign o_MemReq   = i_Reset && mem_req;
  assign o_Freeze   = i_Reset && freeze;
  assign o_FlushID  = i_Reset && branch_act;
  assign o_StallIF  = i_Reset && stall_act;
  assign o_StallID  = i_Reset && stall_act;
  assign o_BubbleEX = i_Reset && (stall_act || branch_act);
  assign o_Error    = i_Reset && (state_q == HS_ERROR);
  assign o_FwdA     = i_Reset ? g_src[0].fwd_sel : FWD_REG;
  assign o_FwdB     = i_Reset ? g_src[1].fwd_sel : FWD_REG;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Inc   (freeze || stall_act),
    .o_Count (o_StallCount)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Inc   (branch_act),
    .o_Count (o_FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding instance and a no-forwarding instance
// with narrow counters share stimulus and are checked against a reference model.
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_u1, id_u2, ex_we, ex_ld, mem_we, mem_acc, wb_we, br, ack;

  logic        memreq1, stif1, stid1, bub1, flid1, frz1, err1;
  logic [1:0]  fwda1, fwdb1;
  logic [31:0] sc1, fc1;
  logic        memreq0, stif0, stid0, bub0, flid0, frz0, err0;
  logic [1:0]  fwda0, fwdb0;
  logic [3:0]  sc0, fc0;

  hazard_ctrl #(.REG_WIDTH(RW), .COUNT_WIDTH(32), .MEM_TIMEOUT(TO), .FWD_ENABLE(1)) dut (
    .i_Clock(clk), .i_Reset(rst_n),
    .i_ID_Rs1(id_rs1), .i_ID_Rs2(id_rs2), .i_ID_Rs1Used(id_u1), .i_ID_Rs2Used(id_u2),
    .i_EX_Rs1(ex_rs1), .i_EX_Rs2(ex_rs2), .i_EX_Rd(ex_rd),
    .i_EX_RegWrEnable(ex_we), .i_EX_IsLoad(ex_ld),
    .i_MEM_Rd(mem_rd), .i_MEM_RegWrEnable(mem_we), .i_MEM_MemAccess(mem_acc),
    .i_WB_Rd(wb_rd), .i_WB_RegWrEnable(wb_we), .i_BranchTaken(br), .i_MemAck(ack),
    .o_MemReq(memreq1), .o_FwdA(fwda1), .o_FwdB(fwdb1), .o_StallIF(stif1), .o_StallID(stid1),
    .o_BubbleEX(bub1), .o_FlushID(flid1), .o_Freeze(frz1), .o_Error(err1),
    .o_StallCount(sc1), .o_FlushCount(fc1));

  hazard_ctrl #(.REG_WIDTH(RW), .COUNT_WIDTH(4), .MEM_TIMEOUT(TO), .FWD_ENABLE(0)) dut0 (
    .i_Clock(clk), .i_Reset(rst_n),
    .i_ID_Rs1(id_rs1), .i_ID_Rs2(id_rs2), .i_ID_Rs1Used(id_u1), .i_ID_Rs2Used(id_u2),
    .i_EX_Rs1(ex_rs1), .i_EX_Rs2(ex_rs2), .i_EX_Rd(ex_rd),
    .i_EX_RegWrEnable(ex_we), .i_EX_IsLoad(ex_ld),
    .i_MEM_Rd(mem_rd), .i_MEM_RegWrEnable(mem_we), .i_MEM_MemAccess(mem_acc),
    .i_WB_Rd(wb_rd), .i_WB_RegWrEnable(wb_we), .i_BranchTaken(br), .i_MemAck(ack),
    .o_MemReq(memreq0), .o_FwdA(fwda0), .o_FwdB(fwdb0), .o_StallIF(stif0), .o_StallID(stid0),
    .o_BubbleEX(bub0), .o_FlushID(flid0), .o_Freeze(frz0), .o_Error(err0),
    .o_StallCount(sc0), .o_FlushCount(fc0));

  // Reference model: memory-wait bookkeeping and expected counter values.
  bit     m_err, m_waiting;
  int     m_wait;
  longint m_sc1, m_fc1, m_sc0, m_fc0;
  bit     e_memreq, e_frz, e_br, e_st1, e_st0;
  int     ncmp = 0;
  int     nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [RW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (mem_we && mem_rd == rs) return 2'b01;
    if (wb_we && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit writer_hit(input logic [RW-1:0] rs, input bit used);
    if (!used || rs == 0) return 1'b0;
    return (ex_we && ex_rd == rs) || (mem_we && mem_rd == rs) || (wb_we && wb_rd == rs);
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic check_outputs();
    bit h1, h0;
    h1 = ex_ld && ex_rd != 0 && ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
    h0 = writer_hit(id_rs1, id_u1) || writer_hit(id_rs2, id_u2);
    e_memreq = rst_n && mem_acc && !m_err;
    e_frz    = rst_n && ((e_memreq && !ack) || m_err);
    e_br     = rst_n && br && !e_frz;
    e_st1    = rst_n && h1 && !e_frz && !e_br;
    e_st0    = rst_n && h0 && !e_frz && !e_br;
    chk("memreq", memreq1, e_memreq);
    chk("freeze", frz1, e_frz);
    chk("error", err1, rst_n && m_err);
    chk("flushID", flid1, e_br);
    chk("stallIF", stif1, e_st1);
    chk("stallID", stid1, e_st1);
    chk("bubbleEX", bub1, e_st1 || e_br);
    chk("fwdA", fwda1, rst_n ? fwd_of(ex_rs1) : 2'b00);
    chk("fwdB", fwdb1, rst_n ? fwd_of(ex_rs2) : 2'b00);
    chk("stallCnt", sc1, m_sc1);
    chk("flushCnt", fc1, m_fc1);
    chk("memreq0", memreq0, e_memreq);
    chk("freeze0", frz0, e_frz);
    chk("error0", err0, rst_n && m_err);
    chk("flushID0", flid0, e_br);
    chk("stallIF0", stif0, e_st0);
    chk("bubbleEX0", bub0, e_st0 || e_br);
    chk("fwdA0", fwda0, 0);
    chk("fwdB0", fwdb0, 0);
    chk("stallCnt0", sc0, m_sc0);
    chk("flushCnt0", fc0, m_fc0);
  endtask

  task automatic update_model();
    if (e_frz || e_st1) m_sc1 = sat(m_sc1, 64'hFFFF_FFFF);
    if (e_frz || e_st0) m_sc0 = sat(m_sc0, 15);
    if (e_br) begin
      m_fc1 = sat(m_fc1, 64'hFFFF_FFFF);
      m_fc0 = sat(m_fc0, 15);
    end
    if (!m_err) begin
      if (!m_waiting) begin
        if (e_memreq && !ack) begin m_waiting = 1; m_wait = 1; end
      end else if (ack) begin
        m_waiting = 0; m_wait = 0;
      end else if (m_wait == TO) begin
        m_err = 1; m_waiting = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    $display("step t=%0t rst_n=%0b fwdA=%0d stall=%0b flush=%0b freeze=%0b err=%0b sc=%0d fc=%0d",
             $time, rst_n, fwda1, stif1, flid1, frz1, err1, sc1, fc1);
    @(posedge clk);
    if (rst_n) update_model();
    @(negedge clk);
  endtask

  task automatic clr();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_u1, id_u2, ex_we, ex_ld, mem_we, mem_acc, wb_we, br, ack} = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_err = 0; m_waiting = 0; m_wait = 0;
    m_sc1 = 0; m_fc1 = 0; m_sc0 = 0; m_fc0 = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clr();
    @(negedge clk);
    do_reset();

    // Load-use then forward from MEM on the following cycle.
    clr(); ex_ld = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_u1 = 1; step();
    clr(); ex_rs1 = 5; mem_rd = 5; mem_we = 1; step();
    chk("loaduse_cnt", sc1, 1);

    // Forward priority MEM > WB, then x0.
    clr(); ex_rs1 = 3; mem_rd = 3; mem_we = 1; wb_rd = 3; wb_we = 1; step();
    mem_we = 0; step();
    ex_rs1 = 0; step();

    // Memory wait: ack on fourth cycle, then a zero-wait access.
    clr(); mem_acc = 1;
    repeat (3) step();
    ack = 1; step();
    step();

    // Branch with simultaneous load-use; branch held through a freeze.
    clr(); br = 1; ex_ld = 1; ex_we = 1; ex_rd = 5; id_rs1 = 5; id_u1 = 1; step();
    clr(); br = 1; mem_acc = 1;
    repeat (2) step();
    ack = 1; step();

    // Non-forwarding instance stalls on a WB writer.
    clr(); id_rs2 = 7; id_u2 = 1; wb_rd = 7; wb_we = 1; step();

    // Randomized traffic with a small register pool to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd  = RW'($urandom_range(0, 3));
      id_u1 = 1'($urandom); id_u2 = 1'($urandom);
      ex_we = 1'($urandom); ex_ld = 1'($urandom); mem_we = 1'($urandom); wb_we = 1'($urandom);
      br = ($urandom_range(0, 7) == 0); mem_acc = ($urandom_range(0, 3) == 0);
      ack = 1'($urandom);
      step();
    end
    chk("sat_stall0", sc0, 15);

    // Timeout into sticky error, then reset clears it.
    clr(); ack = 1; step();
    clr(); mem_acc = 1;
    repeat (20) step();
    chk("err_sticky", err1, 1);
    do_reset();
    chk("err_cleared", err1, 0);

    // Reset in the middle of a wait drops the request immediately.
    clr(); mem_acc = 1;
    repeat (2) step();
    do_reset();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage RV32 pipeline.
- Centralises hazard handling: EX operand forwarding selects, load-use/RAW stall, taken-branch flush, and whole-pipeline freeze during variable-latency data-memory access with timeout.
- Exports saturating stall/flush performance counters.
- Sits beside the stage/pipeline-register instances; drives their hold/bubble/flush controls.

Parameters:
- REG_WIDTH, 5, register address width.
- COUNT_WIDTH, 32, width of each performance counter.
- MEM_TIMEOUT, 16, maximum wait cycles for i_MemAck before error (≥2).
- FWD_ENABLE, 1, 1 = forwarding active; 0 = every RAW hazard stalls, forward selects tied to register file.

Ports:
- i_Clock  in  1  clock, rising edge.
- i_Reset  in  1  asynchronous reset, active-low.
- i_ID_Rs1, i_ID_Rs2  in  REG_WIDTH  source registers of the instruction in ID.
- i_ID_Rs1Used, i_ID_Rs2Used  in  1  source actually read.
- i_EX_Rs1, i_EX_Rs2  in  REG_WIDTH  source registers of the instruction in EX.
- i_EX_Rd  in  REG_WIDTH  EX destination.
- i_EX_RegWrEnable  in  1  EX writes a register.
- i_EX_IsLoad  in  1  EX instruction is a load.
- i_MEM_Rd  in  REG_WIDTH  MEM destination.
- i_MEM_RegWrEnable  in  1  MEM writes a register.
- i_MEM_MemAccess  in  1  MEM instruction is a load/store.
- i_WB_Rd  in  REG_WIDTH  WB destination.
- i_WB_RegWrEnable  in  1  WB writes a register.
- i_BranchTaken  in  1  branch/jump resolved taken in EX.
- i_MemAck  in  1  data memory completes the access this cycle.
- o_MemReq  out  1  data memory request.
- o_FwdA, o_FwdB  out  2  EX operand select: 00 regfile, 01 from MEM, 10 from WB.
- o_StallIF  out  1  hold PC.
- o_StallID  out  1  hold IF/ID register.
- o_BubbleEX  out  1  load NOP into ID/EX.
- o_FlushID  out  1  clear IF/ID.
- o_Freeze  out  1  hold every pipeline register and PC.
- o_Error  out  1  sticky memory timeout.
- o_StallCount  out  COUNT_WIDTH  cycles with any stall or freeze.
- o_FlushCount  out  COUNT_WIDTH  taken branches acted on.

Behaviour:
- Reset (i_Reset=0, async): state RUN, wait counter 0, o_Error 0, both counters 0. While reset is held, all control outputs are 0 and o_FwdA/B=00.
- Register 0 never creates a hazard or a forward.
- Forwarding (FWD_ENABLE=1), combinational, per operand:
  - Select MEM if MEM writes a matching nonzero register.
  - Otherwise select WB if WB writes a matching nonzero register.
  - Otherwise 00. MEM has priority over WB.
- Stall condition (hazard):
  - FWD_ENABLE=1: EX is a load, EX Rd≠0, and EX Rd equals a used ID source.
  - FWD_ENABLE=0: a used nonzero ID source matches any writing Rd in EX, MEM or WB.
- o_MemReq = i_MEM_MemAccess and state≠ERROR.
- Freeze = (o_MemReq and !i_MemAck), or state=ERROR. A zero-wait ack in the same cycle causes no freeze.
- Priority: Freeze > branch > hazard.
  - Freeze: o_Freeze=1; stall/bubble/flush outputs are 0.
  - Branch (i_BranchTaken, no freeze): o_FlushID=1 and o_BubbleEX=1; stall outputs 0. The wrong-path ID instruction is discarded, so the hazard is ignored.
  - Hazard only: o_StallIF=o_StallID=o_BubbleEX=1 for that cycle. The condition re-evaluates each cycle; for a load-use it clears after one cycle.
- FSM:
  - RUN: if o_MemReq and !i_MemAck, go to WAIT with wait counter = 1.
  - WAIT: if i_MemAck, go to RUN and clear the wait counter. Else if wait counter = MEM_TIMEOUT, go to ERROR. Else increment the wait counter.
  - ERROR: sticky until reset; o_Error=1, o_Freeze=1, o_MemReq=0.
- Counters, registered:
  - StallCount +1 on each cycle with Freeze or hazard stall.
  - FlushCount +1 on each cycle with a branch acted on.
  - Both saturate at all-ones.
- Reset mid-WAIT: returns to RUN immediately and drops o_MemReq.

Decomposition:
- Package types gets:
  - FwdSel enum (FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10).
  - HazardState enum (HS_RUN, HS_WAIT, HS_ERROR).
- One sub-module: sat_counter (WIDTH parameter, i_Clock, i_Reset active-low async, i_Inc, o_Count). Instantiated twice.

Test Plan:
- Load-use: EX load Rd=5 (RegWrEnable=1), ID Rs1=5 used → StallIF/StallID/BubbleEX=1 for exactly 1 cycle; StallCount 0→1; FwdA=01 on the next cycle.
- Forward priority: EX Rs1=3, MEM Rd=3 we, WB Rd=3 we → FwdA=01. Drop MEM we → FwdA=10. Set Rs1=0 → FwdA=00.
- Memory wait: MemAccess=1, ack on the 4th cycle → Freeze=1 for 3 cycles, StallCount +3, state returns to RUN. A same-cycle ack gives no freeze.
- Timeout with MEM_TIMEOUT=16 and no ack → Error=1 after 16 WAIT cycles; MemReq=0 and Freeze=1 persist. Asserting reset low clears Error and the counters.
- Branch plus load-use in the same cycle → FlushID=1, BubbleEX=1, StallIF=0, FlushCount +1, StallCount unchanged. Branch during a freeze is held and flushes only after ack.
- FWD_ENABLE=0: ID Rs2=7 used, WB Rd=7 we → stall asserted; FwdA/FwdB stay 00.
